// File: rtl/traffic_pkg.sv
// Shared definitions for the crossroads phase controller: state codes,
// lamp bit positions and BCD helpers used by the countdown.
package traffic_pkg;

    // FSM state encoding; codes 5..7 are illegal and recover to NS_G
    localparam logic [2:0] ST_NS_G  = 3'd0;
    localparam logic [2:0] ST_NS_Y  = 3'd1;
    localparam logic [2:0] ST_EW_G  = 3'd2;
    localparam logic [2:0] ST_EW_Y  = 3'd3;
    localparam logic [2:0] ST_NIGHT = 3'd4;

    // Lamp bit positions inside a {red,yellow,green} light vector
    localparam int RED = 2;
    localparam int YEL = 1;
    localparam int GRN = 0;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Two-digit BCD countdown value
    typedef struct packed {
        logic [3:0] ten;
        logic [3:0] one;
    } bcd_t;

    localparam bcd_t BCD_ZERO = 8'h00;
    localparam bcd_t BCD_LAST = 8'h01;

    function automatic logic [3:0] bcd_ten(input int d);
        return 4'(d / 10);
    endfunction

    function automatic logic [3:0] bcd_one(input int d);
        return 4'(d % 10);
    endfunction

    function automatic bcd_t to_bcd(input int d);
        bcd_t r;
        r.ten = bcd_ten(d);
        r.one = bcd_one(d);
        return r;
    endfunction

    // One-step BCD decrement; callers never pass 00
    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        if (v.one == 4'd0) begin
            r.one = 4'd9;
            r.ten = 4'(v.ten - 4'd1);
        end else begin
            r.one = 4'(v.one - 4'd1);
            r.ten = v.ten;
        end
        return r;
    endfunction

    // Night light pattern: only the yellow lamp, following the flash bit
    function automatic logic [2:0] night_lamp(input logic flash);
        logic [2:0] r;
        r      = LAMP_OFF;
        r[YEL] = flash;
        return r;
    endfunction

endpackage

// File: rtl/traffic_phase_cnt_tick_gen.sv
// Free-running modulo-TICK_DIV divider producing a one-cycle strobe on its
// last count. clr forces the count to 0 and suppresses the strobe; en=0
// holds the count.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div;
    logic          at_last;

    assign at_last = (div == LAST);

    // Divider count: clear beats enable, wrap on the last count
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div <= '0;
        end else if (en) begin
            div <= at_last ? '0 : DW'(div + 1'b1);
        end
    end

    assign tick = at_last & en & ~clr;

endmodule

// File: rtl/traffic_phase_cnt.sv
// Crossroads traffic-light phase controller. Steps NS/EW lights through
// green/yellow/red with a two-digit BCD countdown of the current phase,
// and falls into a flashing-yellow night mode with the display blanked.
module traffic_phase_cnt
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int GREEN_T  = 25,
    parameter int YELLOW_T = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       night,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [3:0] cnt_ten,
    output logic [3:0] cnt_one,
    output logic       blank,
    output logic       tick
);

    // Phase durations as BCD digit pairs
    localparam logic [3:0] GREEN_TEN  = bcd_ten(GREEN_T);
    localparam logic [3:0] GREEN_ONE  = bcd_one(GREEN_T);
    localparam logic [3:0] YELLOW_TEN = bcd_ten(YELLOW_T);
    localparam logic [3:0] YELLOW_ONE = bcd_one(YELLOW_T);
    localparam bcd_t GREEN_BCD  = {GREEN_TEN, GREEN_ONE};
    localparam bcd_t YELLOW_BCD = {YELLOW_TEN, YELLOW_ONE};

    logic [2:0] state, state_nxt;
    bcd_t       cnt, cnt_nxt;
    logic       flash, flash_nxt;
    logic       blank_nxt;
    logic [2:0] ns_nxt, ew_nxt;
    logic       in_night;
    logic       sec_en, sec_clr;
    logic       flash_en, flash_clr, flash_tick;

    assign in_night = (state == ST_NIGHT);

    // 1 s strobe: held by pause, cleared while night is requested and on
    // the cycle leaving NIGHT so a fresh green always starts at div=0.
    assign sec_en  = ~pause;
    assign sec_clr = night | in_night;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .en   (sec_en),
        .clr  (sec_clr),
        .tick (tick)
    );

    // Night flash uses its own divider, running only inside NIGHT and
    // deliberately ignoring pause.
    assign flash_en  = in_night;
    assign flash_clr = ~in_night;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_flash (
        .clk  (clk),
        .rst  (rst),
        .en   (flash_en),
        .clr  (flash_clr),
        .tick (flash_tick)
    );

    // Next-state, countdown and flash logic; night overrides everything
    // except reset, and pause acts only through the missing tick.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flash_nxt = flash;
        blank_nxt = blank;
        if (night) begin
            state_nxt = ST_NIGHT;
            cnt_nxt   = BCD_ZERO;
            blank_nxt = 1'b1;
            // Entry always shows the yellows lit first
            flash_nxt = in_night ? (flash ^ flash_tick) : 1'b1;
        end else begin
            flash_nxt = 1'b0;
            blank_nxt = 1'b0;
            case (state)
                ST_NS_G: begin
                    if (tick) begin
                        if (cnt == BCD_LAST) begin
                            state_nxt = ST_NS_Y;
                            cnt_nxt   = YELLOW_BCD;
                        end else begin
                            cnt_nxt = bcd_dec(cnt);
                        end
                    end
                end
                ST_NS_Y: begin
                    if (tick) begin
                        if (cnt == BCD_LAST) begin
                            state_nxt = ST_EW_G;
                            cnt_nxt   = GREEN_BCD;
                        end else begin
                            cnt_nxt = bcd_dec(cnt);
                        end
                    end
                end
                ST_EW_G: begin
                    if (tick) begin
                        if (cnt == BCD_LAST) begin
                            state_nxt = ST_EW_Y;
                            cnt_nxt   = YELLOW_BCD;
                        end else begin
                            cnt_nxt = bcd_dec(cnt);
                        end
                    end
                end
                ST_EW_Y: begin
                    if (tick) begin
                        if (cnt == BCD_LAST) begin
                            state_nxt = ST_NS_G;
                            cnt_nxt   = GREEN_BCD;
                        end else begin
                            cnt_nxt = bcd_dec(cnt);
                        end
                    end
                end
                default: begin
                    // Leaving NIGHT, or recovering from an illegal code
                    state_nxt = ST_NS_G;
                    cnt_nxt   = GREEN_BCD;
                end
            endcase
        end
    end

    // Light pattern decoded from the next state so lamps move with it
    always_comb begin
        ns_nxt = LAMP_G;
        ew_nxt = LAMP_R;
        case (state_nxt)
            ST_NS_G: begin
                ns_nxt = LAMP_G;
                ew_nxt = LAMP_R;
            end
            ST_NS_Y: begin
                ns_nxt = LAMP_Y;
                ew_nxt = LAMP_R;
            end
            ST_EW_G: begin
                ns_nxt = LAMP_R;
                ew_nxt = LAMP_G;
            end
            ST_EW_Y: begin
                ns_nxt = LAMP_R;
                ew_nxt = LAMP_Y;
            end
            ST_NIGHT: begin
                ns_nxt = night_lamp(flash_nxt);
                ew_nxt = night_lamp(flash_nxt);
            end
            default: begin
                ns_nxt = LAMP_G;
                ew_nxt = LAMP_R;
            end
        endcase
    end

    // Output and state registers with synchronous reset to NS_G
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_NS_G;
            cnt      <= GREEN_BCD;
            flash    <= 1'b0;
            blank    <= 1'b0;
            ns_light <= LAMP_G;
            ew_light <= LAMP_R;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            flash    <= flash_nxt;
            blank    <= blank_nxt;
            ns_light <= ns_nxt;
            ew_light <= ew_nxt;
        end
    end

    assign cnt_ten = cnt.ten;
    assign cnt_one = cnt.one;

endmodule

// File: tb/tb_traffic_phase_cnt.sv
// Directed bench for traffic_phase_cnt: main instance with TICK_DIV=4,
// GREEN_T=12, YELLOW_T=3 and a second with one-tick phases.
module tb_traffic_phase_cnt;

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LO = 3'b000;

    logic       clk;
    logic       rst, pause, night;
    logic [2:0] ns_light, ew_light;
    logic [3:0] cnt_ten, cnt_one;
    logic       blank, tick;

    logic       rst1, pause1, night1;
    logic [2:0] ns_light1, ew_light1;
    logic [3:0] cnt_ten1, cnt_one1;
    logic       blank1, tick1;

    int passed = 0;
    int total  = 0;

    traffic_phase_cnt #(.TICK_DIV(4), .GREEN_T(12), .YELLOW_T(3)) dut (
        .clk(clk), .rst(rst), .pause(pause), .night(night),
        .ns_light(ns_light), .ew_light(ew_light),
        .cnt_ten(cnt_ten), .cnt_one(cnt_one),
        .blank(blank), .tick(tick)
    );

    traffic_phase_cnt #(.TICK_DIV(4), .GREEN_T(1), .YELLOW_T(1)) dut1 (
        .clk(clk), .rst(rst1), .pause(pause1), .night(night1),
        .ns_light(ns_light1), .ew_light(ew_light1),
        .cnt_ten(cnt_ten1), .cnt_one(cnt_one1),
        .blank(blank1), .tick(tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ns_e, input logic [2:0] ew_e,
                           input int c, input logic b);
        chk({tag, " ns"}, {5'b0, ns_light}, {5'b0, ns_e});
        chk({tag, " ew"}, {5'b0, ew_light}, {5'b0, ew_e});
        chk({tag, " cnt"}, {cnt_ten, cnt_one}, bcd8(c));
        chk({tag, " blank"}, {7'b0, blank}, {7'b0, b});
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] ns_e, ew_e;
        int dur;
        rst = 1'b1; pause = 1'b0; night = 1'b0;
        rst1 = 1'b1; pause1 = 1'b0; night1 = 1'b0;

        // Reset state
        step(1);
        chk_all("reset", LG, LR, 12, 1'b0);
        chk("reset tick", {7'b0, tick}, 8'h00);
        rst = 1'b0;

        // One full cycle: 4 phases, each value held exactly 4 clocks
        for (int p = 0; p < 4; p++) begin
            dur  = (p % 2 == 0) ? 12 : 3;
            ns_e = (p == 0) ? LG : (p == 1) ? LY : LR;
            ew_e = (p == 2) ? LG : (p == 3) ? LY : LR;
            for (int v = dur; v >= 1; v--) begin
                chk_all($sformatf("run p%0d v%0d", p, v), ns_e, ew_e, v, 1'b0);
                step(3);
                chk($sformatf("run tick p%0d v%0d", p, v), {7'b0, tick}, 8'h01);
                step(1);
            end
        end
        chk_all("wrap 120clk", LG, LR, 12, 1'b0);

        // Pause mid-count at 07 with div=2
        step(20);
        chk_all("pre pause", LG, LR, 7, 1'b0);
        step(2);
        pause = 1'b1;
        step(10);
        chk_all("paused", LG, LR, 7, 1'b0);
        chk("paused tick", {7'b0, tick}, 8'h00);
        pause = 1'b0;
        step(1);
        chk_all("resume 1", LG, LR, 7, 1'b0);
        chk("resume tick", {7'b0, tick}, 8'h01);
        step(1);
        chk_all("resume 2", LG, LR, 6, 1'b0);

        // Pause exactly on the last divider count
        step(3);
        pause = 1'b1;
        #1;
        chk("pause at last tick", {7'b0, tick}, 8'h00);
        step(3);
        chk_all("pause at last", LG, LR, 6, 1'b0);
        pause = 1'b0;
        #1;
        chk("release tick", {7'b0, tick}, 8'h01);
        step(1);
        chk_all("release dec", LG, LR, 5, 1'b0);

        // Night mode entered during EW_G
        step(32);
        chk_all("ew green", LR, LG, 12, 1'b0);
        step(2);
        night = 1'b1;
        step(1);
        chk_all("night entry", LY, LY, 0, 1'b1);
        chk("night tick", {7'b0, tick}, 8'h00);
        step(3);
        chk_all("night hold", LY, LY, 0, 1'b1);
        step(1);
        chk_all("night off", LO, LO, 0, 1'b1);
        pause = 1'b1;
        step(4);
        chk_all("night flash w/ pause", LY, LY, 0, 1'b1);
        pause = 1'b0;
        night = 1'b0;
        step(1);
        chk_all("night exit", LG, LR, 12, 1'b0);
        step(3);
        chk("exit tick", {7'b0, tick}, 8'h01);
        step(1);
        chk_all("exit dec", LG, LR, 11, 1'b0);

        // Reset during NS_Y at 02
        step(48);
        chk_all("ns yellow 02", LY, LR, 2, 1'b0);
        step(1);
        rst = 1'b1;
        step(1);
        chk_all("mid reset", LG, LR, 12, 1'b0);
        rst = 1'b0;
        step(3);
        chk("post reset tick", {7'b0, tick}, 8'h01);
        step(1);
        chk_all("post reset dec", LG, LR, 11, 1'b0);

        // Reset beats night
        rst = 1'b1;
        night = 1'b1;
        step(1);
        chk_all("rst+night", LG, LR, 12, 1'b0);
        rst = 1'b0;
        night = 1'b0;
        step(1);
        chk_all("after rst+night", LG, LR, 12, 1'b0);

        // One-tick phases: every tick advances, display stays 01
        rst1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ns_e = (k % 4 == 0) ? LG : (k % 4 == 1) ? LY : LR;
            ew_e = (k % 4 == 2) ? LG : (k % 4 == 3) ? LY : LR;
            chk($sformatf("short ns k%0d", k), {5'b0, ns_light1}, {5'b0, ns_e});
            chk($sformatf("short ew k%0d", k), {5'b0, ew_light1}, {5'b0, ew_e});
            chk($sformatf("short cnt k%0d", k), {cnt_ten1, cnt_one1}, 8'h01);
            step(3);
            chk($sformatf("short cnt late k%0d", k), {cnt_ten1, cnt_one1}, 8'h01);
            chk($sformatf("short tick k%0d", k), {7'b0, tick1}, 8'h01);
            step(1);
        end
        chk($sformatf("short blank"), {7'b0, blank1}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
